load_unit: RTL

- Load-side counterpart of the store byte-enable logic: executes lw/lb/lbu between the pipeline and a data memory whose read latency varies.
- Issues a word-aligned read request, waits for the memory acknowledge, then selects the addressed byte and extends it to 32 bits (lb/lbu) or passes the whole word (lw).
- Returns the result with a one-cycle valid pulse.
- Holds a busy flag that the hazard unit uses to stall the pipeline.

---
 rtl/load_store_pkg.sv | 19 +
 rtl/load_unit_if.sv | 27 ++
 rtl/load_align.sv | 31 +++
 rtl/load_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Types and constants shared by the load and store byte-lane logic.
package load_store_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDone,
    StErr
  } state_e;

  localparam logic DT_WORD = 1'b1;
  localparam logic DT_BYTE = 1'b0;

  localparam logic [1:0] OFF_B0 = 2'b00;
  localparam logic [1:0] OFF_B1 = 2'b01;
  localparam logic [1:0] OFF_B2 = 2'b10;
  localparam logic [1:0] OFF_B3 = 2'b11;

endpackage

// File: rtl/load_unit_if.sv
// Pipeline-side load request/response and data-memory read port of the load unit.
interface load_unit_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_dt;
  logic        ld_signed;
  logic        busy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_err;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Load unit side
  modport slave (
    input  ld_req, ld_addr, ld_dt, ld_signed, mem_rdata, mem_ack,
    output busy, ld_valid, ld_data, ld_err, mem_rd, mem_addr
  );

  // Pipeline plus data memory side
  modport master (
    output ld_req, ld_addr, ld_dt, ld_signed, mem_rdata, mem_ack,
    input  busy, ld_valid, ld_data, ld_err, mem_rd, mem_addr
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte of a read word and extends it; words pass through untouched.
module load_align
  import load_store_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic        dt,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (off)
      OFF_B0: byte_sel = rdata[7:0];
      OFF_B1: byte_sel = rdata[15:8];
      OFF_B2: byte_sel = rdata[23:16];
      OFF_B3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    if (dt == DT_BYTE) begin
      data = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
    end else begin
      data = rdata;
    end
  end

endmodule

// File: rtl/load_unit.sv
// Executes lw/lb/lbu against a variable-latency data memory with a read timeout.
module load_unit
  import load_store_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  load_unit_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic              dt_q, dt_d;
  logic              sgn_q, sgn_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       aligned;
  logic              misaligned;
  logic              timeout;

  assign misaligned = (bus.ld_dt == DT_WORD) && (bus.ld_addr[1:0] != OFF_B0);
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT - 1));

  load_align u_align (
    .rdata    (bus.mem_rdata),
    .off      (off_q),
    .dt       (dt_q),
    .sign_ext (sgn_q),
    .data     (aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ld_req) begin
          state_d = misaligned ? StErr : StRead;
        end
      end
      // An acknowledge on the final allowed cycle still completes the load.
      StRead: begin
        if (bus.mem_ack) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    off_d   = off_q;
    dt_d    = dt_q;
    sgn_d   = sgn_q;
    data_d  = data_q;
    addr_d  = addr_q;
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StDone);
    err_d   = (state_d == StErr);
    rd_d    = (state_d == StRead);

    unique case (state_q)
      StIdle: begin
        if (bus.ld_req && !misaligned) begin
          off_d  = bus.ld_addr[1:0];
          dt_d   = bus.ld_dt;
          sgn_d  = bus.ld_signed;
          addr_d = {bus.ld_addr[31:2], 2'b00};
          cnt_d  = '0;
        end
      end
      StRead: begin
        if (bus.mem_ack) begin
          data_d = aligned;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d == StErr) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      off_q   <= OFF_B0;
      dt_q    <= DT_BYTE;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      dt_q    <= dt_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ld_valid = valid_q;
  assign bus.ld_err   = err_q;
  assign bus.ld_data  = data_q;
  assign bus.mem_rd   = rd_q;
  assign bus.mem_addr = addr_q;

endmodule
